// File: rtl/mux41_scan_ctrl.sv
// Select sequencer for a 4:1 mux. Frame valid arrives 4*(SETTLE_CYC+1) cycles after start.
// Backpressure: HOLD stalls with data and select frozen until frame_ready is high.
module mux41_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       s1,
  output logic       s0,
  output logic [3:0] frame_data,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("mux41_scan_ctrl: SETTLE_CYC=%0d outside legal range 1..15", SETTLE_CYC);
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYC - 1);

  state_t     state_q;
  logic [1:0] sel_q;
  logic [3:0] cnt_q;
  logic [2:0] shadow_q;
  logic [3:0] frame_q;
  logic       valid_q;
  logic       busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 3'b000;
      frame_q  <= 4'b0000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETTLE;
            sel_q   <= 2'd0;
            cnt_q   <= RELOAD;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == 4'd0) state_q <= SAMPLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        SAMPLE: begin
          // Channel 3 goes straight into the frame; only d0..d2 need shadowing.
          case (sel_q)
            2'd0: shadow_q[0] <= y_in;
            2'd1: shadow_q[1] <= y_in;
            2'd2: shadow_q[2] <= y_in;
            default: begin
              frame_q <= {y_in, shadow_q};
              valid_q <= 1'b1;
            end
          endcase
          if (sel_q == 2'd3) begin
            state_q <= HOLD;
          end else begin
            sel_q   <= sel_q + 2'd1;
            cnt_q   <= RELOAD;
            state_q <= SETTLE;
          end
        end
        HOLD: begin
          if (frame_ready) begin
            valid_q <= 1'b0;
            sel_q   <= 2'd0;
            if (CONTINUOUS) begin
              cnt_q   <= RELOAD;
              state_q <= SETTLE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s1          = sel_q[1];
  assign s0          = sel_q[0];
  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Directed bench: default single-shot instance plus a CONTINUOUS, SETTLE_CYC=3 instance.
module tb_mux41_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       start_a = 1'b0;
  logic       ready_a = 1'b0;
  logic [3:0] d_a = 4'b0000;
  logic       y_a, s1_a, s0_a, fv_a, busy_a;
  logic [3:0] fd_a;
  assign y_a = d_a[{s1_a, s0_a}];

  mux41_scan_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y_in(y_a),
    .s1(s1_a), .s0(s0_a), .frame_data(fd_a), .frame_valid(fv_a),
    .frame_ready(ready_a), .busy(busy_a)
  );

  // Instance B: continuous rescan, longer settle, ready tied high
  logic       start_b = 1'b0;
  logic       ready_b = 1'b1;
  logic [3:0] d_b = 4'b0110;
  logic       y_b, s1_b, s0_b, fv_b, busy_b;
  logic [3:0] fd_b;
  assign y_b = d_b[{s1_b, s0_b}];

  mux41_scan_ctrl #(.SETTLE_CYC(3), .CONTINUOUS(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y_in(y_b),
    .s1(s1_b), .s0(s0_b), .frame_data(fd_b), .frame_valid(fv_b),
    .frame_ready(ready_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with start asserted: reset must win
    #1;
    rst_n   = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    tick();
    check("rst_sel",   8'({s1_a, s0_a}), 8'd0);
    check("rst_valid", 8'(fv_a),         8'd0);
    check("rst_busy",  8'(busy_a),       8'd0);
    check("rst_data",  8'(fd_a),         8'd0);
    check("rst_busy_b", 8'(busy_b),      8'd0);
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n   = 1'b1;
    tick();
    check("post_rst_idle", 8'(busy_a), 8'd0);

    // Basic frame d0..d3 = 1,0,1,1 with a second start pulse at k+3
    d_a     = 4'b1101;
    start_a = 1'b1;
    tick();                       // edge k
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("scan_sel_%0d", i), 8'({s1_a, s0_a}), 8'(i / 2));
      check($sformatf("scan_busy_%0d", i), 8'(busy_a), 8'd1);
      check($sformatf("scan_valid_%0d", i), 8'(fv_a), 8'd0);
      start_a = (i == 2);
      tick();
    end
    start_a = 1'b0;
    check("frame_valid", 8'(fv_a), 8'd1);
    check("frame_data",  8'(fd_a), 8'b1101);

    // Backpressure: inputs wander, frame and select must stay frozen
    for (int i = 0; i < 20; i++) begin
      d_a = 4'(i * 5 + 2);
      tick();
      check($sformatf("bp_valid_%0d", i), 8'(fv_a), 8'd1);
      check($sformatf("bp_data_%0d", i),  8'(fd_a), 8'b1101);
      check($sformatf("bp_sel_%0d", i),   8'({s1_a, s0_a}), 8'd3);
    end
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    check("accept_valid", 8'(fv_a), 8'd0);
    check("accept_busy",  8'(busy_a), 8'd0);
    check("accept_sel",   8'({s1_a, s0_a}), 8'd0);
    check("accept_data_kept", 8'(fd_a), 8'b1101);
    for (int i = 0; i < 10; i++) tick();
    check("one_frame_only", 8'({busy_a, fv_a}), 8'd0);

    // Reset mid-scan at k+5
    d_a     = 4'b1111;
    start_a = 1'b1;
    tick();                       // edge k
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_sel", 8'({s1_a, s0_a}), 8'd2);
    rst_n = 1'b0;
    tick();                       // edge k+5
    rst_n = 1'b1;
    check("midrst_sel",   8'({s1_a, s0_a}), 8'd0);
    check("midrst_busy",  8'(busy_a), 8'd0);
    check("midrst_valid", 8'(fv_a),   8'd0);
    check("midrst_data",  8'(fd_a),   8'd0);

    // Fresh scan with ready held high throughout (no effect outside HOLD)
    d_a     = 4'b0100;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("fresh_not_early", 8'(fv_a), 8'd0);
    tick();
    check("fresh_valid", 8'(fv_a), 8'd1);
    check("fresh_data",  8'(fd_a), 8'b0100);
    tick();
    check("fresh_accept_valid", 8'(fv_a), 8'd0);
    check("fresh_accept_busy",  8'(busy_a), 8'd0);
    check("fresh_data_kept",    8'(fd_a), 8'b0100);
    ready_a = 1'b0;

    // Continuous instance: 4-cycle dwell per channel, 17-cycle frame period
    start_b = 1'b1;
    tick();                       // edge m
    start_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("cont_sel_%0d", i), 8'({s1_b, s0_b}), 8'(i / 4));
      check($sformatf("cont_valid_%0d", i), 8'(fv_b), 8'd0);
      tick();
    end
    check("cont_first_valid", 8'(fv_b), 8'd1);
    check("cont_first_data",  8'(fd_b), 8'b0110);
    for (int f = 0; f < 2; f++) begin
      int  cyc;
      bit  seen;
      cyc  = 0;
      seen = 1'b0;
      for (int j = 0; j < 30 && !seen; j++) begin
        tick();
        cyc++;
        if (fv_b) seen = 1'b1;
      end
      check($sformatf("cont_period_%0d", f), 8'(cyc), 8'd17);
      check($sformatf("cont_data_%0d", f), 8'(fd_b), 8'b0110);
      check($sformatf("cont_busy_%0d", f), 8'(busy_b), 8'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux41_scan_ctrl.md
Name: mux41_scan_ctrl

Overview:
Upstream select sequencer for the 4:1 NAND mux (mux41_nand). It steps the mux select lines through channels d0..d3 and waits a programmable settle time on each channel. It then samples the mux output y and packs the four samples into a 4-bit frame. The frame is presented downstream with a valid/ready handshake, and the controller stalls under backpressure.

Parameters:
SETTLE_CYC, 1, cycles select is held stable before sampling y_in; legal range 1..15
CONTINUOUS, 0, 1 = rescan automatically after each accepted frame; 0 = single-shot per start pulse

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  begin a scan; sampled only in IDLE
y_in  input  1  mux output y from mux41_nand
s1  output  1  mux select MSB (registered)
s0  output  1  mux select LSB (registered)
frame_data  output  4  bit i = sample of channel i (bit0 = d0 ... bit3 = d3)
frame_valid  output  1  frame_data valid; held until accepted
frame_ready  input  1  downstream accepts frame when high with frame_valid
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n); it is sampled on the rising clk edge and takes priority over all other inputs.
- Reset values: s1=0, s0=0, frame_data=4'b0000, frame_valid=0, busy=0. State is IDLE, channel index sel=0, settle counter=0, shadow register=0.
- {s1,s0} always equals sel, driven from a register. There is no combinational path from any input to any output.
- States and transitions:
  - IDLE: if start=1, go to SETTLE with sel=0 and counter=SETTLE_CYC-1. Otherwise stay in IDLE.
  - SETTLE: if counter=0, go to SAMPLE. Otherwise decrement the counter. Duration is exactly SETTLE_CYC cycles.
  - SAMPLE (1 cycle): shadow[sel] <= y_in.
    - If sel<3: sel<=sel+1, counter reloads to SETTLE_CYC-1, go to SETTLE.
    - If sel=3: frame_data <= {y_in, shadow[2:0]}, frame_valid<=1, go to HOLD. sel stays 3.
  - HOLD: frame_valid=1; frame_data and {s1,s0} are stable. When frame_valid and frame_ready are both high on an edge:
    - frame_valid<=0.
    - If CONTINUOUS=1: sel<=0, counter reload, go to SETTLE.
    - Else: sel<=0, go to IDLE.
- Latency: start sampled at edge k → frame_valid rises after edge k+4*(SETTLE_CYC+1). With the default, that is edge k+8.
- Per-channel cost is SETTLE_CYC+1 cycles. A frame costs 4*(SETTLE_CYC+1) cycles plus the HOLD time.
- Boundary cases:
  - start while busy: ignored. It does not restart or extend the scan.
  - start and rst_n=0 on the same edge: reset wins. The block stays in IDLE.
  - Backpressure: frame_ready low in HOLD stalls indefinitely. No samples are taken, no data is lost, and there is no overrun.
  - frame_ready high outside HOLD: no effect.
  - frame_data keeps the last frame after the handshake, until the next SAMPLE of sel=3 loads a new one.
  - Reset mid-scan (any state): all outputs return to their reset values on that edge. The partial shadow is discarded.
  - sel wraps 3→0 only via HOLD acceptance. It never increments past 3.
  - y_in is sampled only in SAMPLE. Glitches during SETTLE have no effect.
  - An SETTLE_CYC value outside 1..15 is a configuration error. Flag it with a simulation-time $error.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 → s1=s0=0, frame_valid=0, busy=0, frame_data=0000. First edge with rst_n=1 is still IDLE.
- Basic frame, default params, mux41_nand model with d0..d3=1,0,1,1: pulse start at edge k → {s1,s0} sequence is 00,00,01,01,10,10,11,11. frame_valid rises after edge k+8 with frame_data=4'b1101. busy=1 from k+1.
- Backpressure: hold frame_ready=0 for 20 cycles after valid and change d inputs meanwhile → frame_valid stays 1, frame_data stays 1101, {s1,s0}=11. Raise frame_ready → valid drops next edge, busy=0 (CONTINUOUS=0).
- start while busy: pulse start again at k+3 → no restart, frame still completes at k+8. One frame only.
- Reset mid-scan: rst_n=0 at edge k+5 → {s1,s0}=00, busy=0. A new start yields a fresh frame matching the d inputs, with no residue from the partial scan.
- CONTINUOUS=1, SETTLE_CYC=3, frame_ready tied 1, d=0,1,1,0: frames 4'b0110 are accepted every 17 cycles (16 scan + 1 HOLD). Each channel's select is held 4 cycles.
